// File: rtl/phase_readout_defs.sv
// Shared definitions for the phase readout block.
//   STATE_W / state_t : FSM state width and type
//   ST_IDLE..ST_DONE  : state encodings
//   TIE_SPIN          : spin value decoded when exactly half the samples agree
package phase_readout_defs;

  localparam int STATE_W = 2;
  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_SETTLE = 2'd1;
  localparam state_t ST_SAMPLE = 2'd2;
  localparam state_t ST_DONE   = 2'd3;

  // 2*agree == W is not a majority, so a tie reads as anti-phase.
  localparam logic TIE_SPIN = 1'b0;

endpackage

// File: rtl/osc_synchronizer.sv
// Multi-flop synchronizer for the free-running oscillator outputs.
//   clk, rstn : sampling clock, async active-low reset
//   d         : raw oscillator bits (asynchronous to clk)
//   q         : last synchronizer stage (osc_s)
module osc_synchronizer #(
  parameter int N           = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  logic [SYNC_STAGES-1:0][N-1:0] sr;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sr <= '0;
    end else begin
      sr[0] <= d;
      for (int s = 1; s < SYNC_STAGES; s++) sr[s] <= sr[s-1];
    end
  end

  assign q = sr[SYNC_STAGES-1];

endmodule

// File: rtl/phase_readout.sv
// Phase readout for the coupled-oscillator Ising array.
// Counts, over a W-cycle window, how often each oscillator matches
// oscillator 0 and decodes a spin vector (majority in-phase -> 1).
//   clk, rstn     : sampling clock, async active-low reset
//   osc_in        : raw oscillator outputs (asynchronous)
//   start         : request a readout (taken only in IDLE)
//   window_cycles : window length W, latched on start
//   ack           : consumer takes the result while valid
//   busy          : readout in progress
//   valid         : spins/agree_max hold a fresh result
//   spins         : decoded spins, bit 0 always 1
//   agree_max     : largest agree count over oscillators 1..N-1
module phase_readout
  import phase_readout_defs::*;
#(
  parameter int N           = 3,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [N-1:0]     osc_in,
  input  logic             start,
  input  logic [CNT_W-1:0] window_cycles,
  input  logic             ack,
  output logic             busy,
  output logic             valid,
  output logic [N-1:0]     spins,
  output logic [CNT_W-1:0] agree_max
);

  localparam int SETTLE_W = $clog2(SYNC_STAGES);

  state_t                state, state_nxt;
  logic [N-1:0]          osc_s;
  logic [CNT_W-1:0]      w_q;
  logic [SETTLE_W-1:0]   settle_cnt;
  logic [CNT_W-1:0]      sample_cnt;
  logic [CNT_W-1:0]      agree [N];
  logic                  accept, settle_done, sample_done, sampling;
  logic [N-1:0]          spins_dec;
  logic [CNT_W-1:0]      max_dec;
  logic [CNT_W:0]        twice;

  osc_synchronizer #(.N(N), .SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rstn(rstn),
    .d   (osc_in),
    .q   (osc_s)
  );

  assign accept      = (state == ST_IDLE) && start;
  assign settle_done = (settle_cnt == SETTLE_W'(SYNC_STAGES - 1));
  // SAMPLE spends W counting cycles plus one closing cycle in which the
  // finished counters are decoded; with W=0 only the closing cycle remains.
  assign sample_done = (sample_cnt == w_q);
  assign sampling    = (state == ST_SAMPLE) && !sample_done;

  // ---- FSM: state register ----
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // ---- FSM: next state ----
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:   if (start)       state_nxt = ST_SETTLE;
      ST_SETTLE: if (settle_done) state_nxt = ST_SAMPLE;
      ST_SAMPLE: if (sample_done) state_nxt = ST_DONE;
      ST_DONE:   if (ack)         state_nxt = ST_IDLE;
      default:                    state_nxt = ST_IDLE;
    endcase
  end

  // ---- FSM: outputs ----
  always_comb begin
    busy  = (state == ST_SETTLE) || (state == ST_SAMPLE);
    valid = (state == ST_DONE);
  end

  // ---- window latch and phase counters ----
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_q        <= '0;
      settle_cnt <= '0;
      sample_cnt <= '0;
    end else begin
      if (accept) begin
        w_q        <= window_cycles;
        settle_cnt <= '0;
        sample_cnt <= '0;
      end
      if (state == ST_SETTLE) settle_cnt <= settle_cnt + SETTLE_W'(1);
      if (sampling)           sample_cnt <= sample_cnt + CNT_W'(1);
    end
  end

  // ---- per-oscillator agree counters (oscillator 0 is the reference and stays 0) ----
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < N; i++) agree[i] <= '0;
    end else begin
      for (int i = 1; i < N; i++) begin
        if (accept)
          agree[i] <= '0;
        else if (sampling && (osc_s[i] == osc_s[0]))
          agree[i] <= agree[i] + CNT_W'(1);
      end
    end
  end

  // ---- majority decode and max reduction ----
  always_comb begin
    spins_dec    = '0;
    spins_dec[0] = 1'b1;
    max_dec      = '0;
    twice        = '0;
    for (int i = 0; i < N; i++)
      if (agree[i] > max_dec) max_dec = agree[i];
    for (int i = 1; i < N; i++) begin
      twice        = {agree[i], 1'b0};
      spins_dec[i] = (twice > {1'b0, w_q}) ||
                     ((twice == {1'b0, w_q}) && TIE_SPIN);
    end
  end

  // ---- result registers, loaded on DONE entry ----
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      spins     <= '0;
      agree_max <= '0;
    end else if ((state == ST_SAMPLE) && sample_done) begin
      spins     <= spins_dec;
      agree_max <= max_dec;
    end
  end

endmodule

// File: tb/tb_phase_readout.sv
module tb_phase_readout;

  localparam int N     = 3;
  localparam int SS    = 2;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rstn;
  logic [N-1:0]     osc_in;
  logic             start;
  logic [CNT_W-1:0] window_cycles;
  logic             ack;
  logic             busy, valid;
  logic [N-1:0]     spins;
  logic [CNT_W-1:0] agree_max;

  int n_checks = 0;
  int n_fail   = 0;

  // osc_in values presented in the cycles following start acceptance
  logic [N-1:0] pat [64];

  phase_readout #(.N(N), .SYNC_STAGES(SS), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .osc_in       (osc_in),
    .start        (start),
    .window_cycles(window_cycles),
    .ack          (ack),
    .busy         (busy),
    .valid        (valid),
    .spins        (spins),
    .agree_max    (agree_max)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: the readout judges the W osc_in values seen in the W cycles
  // after the accepting edge; spin i is 1 on a strict majority of agreement.
  task automatic model(input int w, output logic [N-1:0] sp, output logic [CNT_W-1:0] am);
    int ag;
    sp = '0;
    sp[0] = 1'b1;
    am = '0;
    for (int i = 1; i < N; i++) begin
      ag = 0;
      for (int t = 0; t < w; t++)
        if (pat[t][i] == pat[t][0]) ag++;
      if (2 * ag > w) sp[i] = 1'b1;
      if (ag > int'(am)) am = CNT_W'(ag);
    end
  endtask

  // Start one readout of window w; returns cycles from accepting edge to valid.
  task automatic do_readout(input int w, input int new_w, input bit noise,
                            output int lat, output bit busy_ok);
    @(negedge clk);
    start = 1'b1; window_cycles = CNT_W'(w); ack = 1'b0;
    @(posedge clk);
    lat = -1; busy_ok = 1'b1;
    for (int t = 0; t < w + 40 && lat < 0; t++) begin
      @(negedge clk);
      if (valid === 1'b1) lat = t;
      else if (busy !== 1'b1) busy_ok = 1'b0;
      osc_in = (t < w) ? pat[t] : N'($urandom);
      start  = (noise && lat < 0) ? 1'($urandom) : 1'b0;
      ack    = (noise && lat < 0) ? 1'($urandom) : 1'b0;
      if (t == 0 && new_w >= 0) window_cycles = CNT_W'(new_w);
    end
    start = 1'b0; ack = 1'b0;
  endtask

  task automatic do_ack();
    @(negedge clk); ack = 1'b1;
    @(negedge clk); ack = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; start = 1'b1; ack = 1'b0; osc_in = '1; window_cycles = 16'd4;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, valid, spins, agree_max} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b valid=%b spins=%b agree_max=%0d, need all 0",
               busy, valid, spins, agree_max);
    end
    start = 1'b0; rstn = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL idle_after_reset: got busy=%b valid=%b, need 0 0", busy, valid);
    end
  endtask

  task automatic test_all_ones();
    int lat; bit bok;
    for (int t = 0; t < 64; t++) pat[t] = '1;
    do_readout(10, -1, 1'b0, lat, bok);
    n_checks++;
    if (lat !== 13 || !bok) begin
      n_fail++; $display("FAIL ones_latency: got %0d busy_ok=%0d, need 13 busy_ok=1", lat, bok);
    end
    n_checks++;
    if (spins !== 3'b111 || agree_max !== 16'd10) begin
      n_fail++; $display("FAIL ones_result: got spins=%b max=%0d, need 111 10", spins, agree_max);
    end
    do_ack();
    n_checks++;
    if (valid !== 1'b0) begin
      n_fail++; $display("FAIL ones_ack: got valid=%b, need 0", valid);
    end
  endtask

  task automatic test_antiphase();
    int lat; bit bok; logic p;
    for (int t = 0; t < 64; t++) begin
      p = 1'((t / 3) % 2);
      pat[t] = {p, ~p, p};
    end
    do_readout(12, -1, 1'b0, lat, bok);
    n_checks++;
    if (lat !== 15 || spins !== 3'b101 || agree_max !== 16'd12) begin
      n_fail++;
      $display("FAIL antiphase: got lat=%0d spins=%b max=%0d, need 15 101 12", lat, spins, agree_max);
    end
    do_ack();
  endtask

  task automatic test_tie();
    int lat; bit bok; logic [7:0] mask; logic o0; int r;
    for (int k = 4; k <= 5; k++) begin
      r = $urandom_range(0, 7);
      mask = (k == 4) ? 8'b0000_1111 : 8'b0001_1111;
      mask = (mask << r) | (mask >> (8 - r));
      for (int t = 0; t < 8; t++) begin
        o0 = 1'($urandom);
        pat[t] = {~o0, mask[t] ? o0 : ~o0, o0};
      end
      do_readout(8, -1, 1'b0, lat, bok);
      n_checks++;
      if (spins !== ((k == 4) ? 3'b001 : 3'b011) || agree_max !== CNT_W'(k)) begin
        n_fail++;
        $display("FAIL tie_%0d_of_8: got spins=%b max=%0d, need %b %0d",
                 k, spins, agree_max, (k == 4) ? 3'b001 : 3'b011, k);
      end
      do_ack();
    end
  endtask

  task automatic test_w_zero();
    int lat; bit bok;
    do_readout(0, -1, 1'b0, lat, bok);
    n_checks++;
    if (lat !== 3 || spins !== 3'b001 || agree_max !== 16'd0) begin
      n_fail++;
      $display("FAIL w_zero: got lat=%0d spins=%b max=%0d, need 3 001 0", lat, spins, agree_max);
    end
    // start while a result is pending is dropped
    start = 1'b1; window_cycles = 16'd7;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_checks++;
      if ({valid, busy, spins} !== 5'b10_001) begin
        n_fail++;
        $display("FAIL start_while_valid: got valid=%b busy=%b spins=%b, need 1 0 001", valid, busy, spins);
      end
    end
    ack = 1'b1;
    @(negedge clk);
    start = 1'b0; ack = 1'b0;
    n_checks++;
    if ({valid, busy} !== 2'b00) begin
      n_fail++; $display("FAIL start_ack_same: got valid=%b busy=%b, need 0 0", valid, busy);
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL start_dropped: got busy=%b, need 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    int lat; bit bok; logic [N-1:0] sp; logic [CNT_W-1:0] am;
    @(negedge clk); start = 1'b1; window_cycles = 16'd20;
    @(negedge clk); start = 1'b0;
    repeat (6) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    n_checks++;
    if ({busy, valid, spins} !== '0) begin
      n_fail++; $display("FAIL reset_mid: got busy=%b valid=%b spins=%b, need 0 0 000", busy, valid, spins);
    end
    @(negedge clk); rstn = 1'b1;
    for (int t = 0; t < 64; t++) pat[t] = N'($urandom);
    do_readout(5, -1, 1'b0, lat, bok);
    model(5, sp, am);
    n_checks++;
    if (lat !== 8 || spins !== sp || agree_max !== am) begin
      n_fail++;
      $display("FAIL after_reset: got lat=%0d spins=%b max=%0d, need 8 %b %0d", lat, spins, agree_max, sp, am);
    end
    do_ack();
  endtask

  task automatic test_window_change();
    int lat; bit bok; logic [N-1:0] sp; logic [CNT_W-1:0] am;
    for (int t = 0; t < 64; t++) pat[t] = N'($urandom);
    do_readout(10, 2, 1'b0, lat, bok);
    model(10, sp, am);
    n_checks++;
    if (lat !== 13 || spins !== sp || agree_max !== am) begin
      n_fail++;
      $display("FAIL window_change: got lat=%0d spins=%b max=%0d, need 13 %b %0d", lat, spins, agree_max, sp, am);
    end
    do_ack();
  endtask

  task automatic test_random();
    int lat; bit bok; int w; logic [N-1:0] sp; logic [CNT_W-1:0] am;
    for (int it = 0; it < 8; it++) begin
      w = $urandom_range(1, 24);
      for (int t = 0; t < 64; t++) pat[t] = N'($urandom);
      do_readout(w, -1, 1'b1, lat, bok);
      model(w, sp, am);
      n_checks++;
      if (lat !== w + SS + 1 || !bok || spins !== sp || agree_max !== am) begin
        n_fail++;
        $display("FAIL random_w%0d: got lat=%0d busy_ok=%0d spins=%b max=%0d, need %0d 1 %b %0d",
                 w, lat, bok, spins, agree_max, w + SS + 1, sp, am);
      end
      do_ack();
    end
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_antiphase();
    test_tie();
    test_w_zero();
    test_reset_mid();
    test_window_change();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/phase_readout.md
Name: phase_readout

Overview:
- Clocked readout that consumes the free-running oscillator outputs of the coupled-cell Ising array (one bit per spin) and decodes them into a binary spin vector.
- Each oscillator is synchronized into the clk domain. Over a programmable sampling window, the block counts cycles in which each oscillator agrees with oscillator 0, the phase reference.
- Result: in-phase = 1, anti-phase = 0. Handshake to the host/control logic is start/busy/valid/ack.

Parameters:
- N, 3, number of oscillators/spins; must match the array's N.
- SYNC_STAGES, 2, synchronizer flop depth per oscillator bit (>=2).
- CNT_W, 16, width of window length and per-oscillator agree counters.

Ports:
- clk  input  1  sampling clock.
- rstn  input  1  asynchronous, active-low reset.
- osc_in  input  N  raw oscillator outputs from the array; asynchronous to clk.
- start  input  1  request a readout; accepted only in IDLE.
- window_cycles  input  CNT_W  number of sample cycles W; latched when start is accepted.
- ack  input  1  consumer acknowledges the result while valid=1.
- busy  output  1  high from start acceptance until valid rises.
- valid  output  1  spins holds a fresh result; held until ack.
- spins  output  N  decoded spin vector; bit 0 is always 1.
- agree_max  output  CNT_W  largest agree count among oscillators 1..N-1 (diagnostic); registered with spins.

Behaviour:
- Reset (async, rstn=0): state=IDLE, busy=0, valid=0, spins=0, agree_max=0, all synchronizer flops=0, all counters=0. Reset mid-operation aborts immediately; no partial result is ever presented.
- Synchronizer: each osc_in bit passes through SYNC_STAGES flops. The sampler sees only the last stage, called osc_s.
- States:
  - IDLE: start=1 latches W=window_cycles, clears counters, and goes to SETTLE. busy=1 from the next cycle.
  - SETTLE: lasts exactly SYNC_STAGES cycles so pre-start synchronizer contents are flushed. Then go to SAMPLE, or straight to DONE if W=0.
  - SAMPLE: lasts exactly W cycles. Each cycle, for i in 1..N-1, agree[i] increments if osc_s[i]==osc_s[0]. A sample counter counts to W. No overflow is possible because agree[i]<=W<=2^CNT_W-1.
  - DONE entry: in the same edge, spins[0]=1, spins[i]=1 iff 2*agree[i] > W (computed at CNT_W+1 bits). A tie decodes as 0. agree_max=max(agree[1..N-1]). valid=1, busy=0.
  - DONE: outputs held stable. ack=1 returns to IDLE and valid=0 next cycle.
- Latency: valid rises SYNC_STAGES+W+1 cycles after the edge that accepted start.
- W=0: skip SAMPLE. Result is spins={N-1 zeros,1}, agree_max=0, and valid rises SYNC_STAGES+1 cycles after start.
- start when not in IDLE (busy or valid pending) is ignored, not queued.
- start and ack in the same cycle while in DONE: ack wins, go to IDLE, start is dropped. A new start is needed the following cycle.
- ack while valid=0: ignored.
- window_cycles changes after acceptance have no effect on the current readout.
- N=1: no counters. spins=1 and agree_max=0 for any W.

Decomposition:
- Shared package/include phase_readout_defs: state encoding localparams (IDLE, SETTLE, SAMPLE, DONE), state width, and the tie-resolution rule constant (tie->0).
- One sub-module: osc_synchronizer (parameters N, SYNC_STAGES; ports clk, rstn, d[N-1:0], q[N-1:0]). It is instantiated once.
- The FSM, counters, comparator and max-reduction stay in phase_readout.

Test Plan:
- All osc_in tied to 1, N=3, W=10, start: valid rises 13 cycles later (SYNC_STAGES=2); spins=3'b111, agree_max=10.
- osc_in[0] toggling every 3 clk, osc_in[1]=~osc_in[0], osc_in[2]=osc_in[0], W=12: spins=3'b101, agree_max=12 (±1 for sync-edge effects, checked at the exact expected value given the chosen phase).
- Tie case: osc_in[1] agrees for exactly 4 of W=8 sampled cycles: spins[1]=0, agree_max=4. With 5 of 8 agreeing: spins[1]=1.
- W=0 start: valid after 3 cycles, spins=3'b001, agree_max=0. A second start while valid=1 with no ack is ignored. Simultaneous start+ack returns to IDLE with valid=0 next cycle and no new busy.
- rstn pulsed low mid-SAMPLE: busy, valid and spins go to 0 immediately (asynchronously). After release, a fresh start with W=5 produces a correct result with latency 8.
- Change window_cycles from 10 to 2 one cycle after start: valid still rises 13 cycles after start.
